// File: rtl/instr_cache_pkg.sv
// instr_cache_pkg: shared sizing defaults, FSM state type and control-bit positions for the instruction cache controller.
package instr_cache_pkg;
   localparam int NUM_SETS_DEF = 64;
   localparam int SET_BITS_DEF = 6;
   localparam int BRANCH_PENDING_BIT = 0;
   localparam int PC_SRC_REDIRECT_BIT = 1;
   typedef enum logic {ST_NORMAL = 1'b0, ST_DELAYED = 1'b1} state_t;
endpackage

// File: rtl/instr_cache_set_sel.sv
// instr_cache_set_sel: one-hot set-enable decoder and per-set miss selection for the fetch index.
module instr_cache_set_sel
   import instr_cache_pkg::*;
#(
   parameter int NUM_SETS = NUM_SETS_DEF,
   parameter int SET_BITS = SET_BITS_DEF
) (
   input  logic [SET_BITS-1:0] set_i,
   input  logic [NUM_SETS-1:0] miss_array_i,
   output logic [NUM_SETS-1:0] active_array_o,
   output logic                instr_miss_f_o
);
   assign active_array_o = NUM_SETS'(1) << set_i;
   assign instr_miss_f_o = miss_array_i[set_i];
endmodule

// File: rtl/instr_cache_ctlr.sv
// instr_cache_ctlr: holds off cache line replacement for one cycle when a fetch misses under an unresolved branch.
// Optional INSTR_CACHE_CTLR_STATS_EN adds delay/squash event counters.
module instr_cache_ctlr
   import instr_cache_pkg::*;
#(
   parameter int NUM_SETS = NUM_SETS_DEF,
   parameter int SET_BITS = SET_BITS_DEF
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic [SET_BITS-1:0] set_i,
   input  logic [NUM_SETS-1:0] miss_array_i,
   input  logic [1:0]          pc_src_reg_i,
   input  logic [1:0]          branch_op_e_i,
   output logic [NUM_SETS-1:0] active_array_o,
   output logic                instr_miss_f_o,
   output logic                instr_cache_rep_active_o
`ifdef INSTR_CACHE_CTLR_STATS_EN
   ,
   output logic [31:0]         delay_count_o,
   output logic [31:0]         squash_count_o
`endif
);
   state_t delay_applied, next_state;
   logic   stall_req, redirect;
   logic   unused_bits;
   assign unused_bits = ^{pc_src_reg_i[0], branch_op_e_i[1]};
   instr_cache_set_sel #(.NUM_SETS(NUM_SETS), .SET_BITS(SET_BITS)) u_set_sel (
      .set_i          (set_i),
      .miss_array_i   (miss_array_i),
      .active_array_o (active_array_o),
      .instr_miss_f_o (instr_miss_f_o)
   );
   assign stall_req = branch_op_e_i[BRANCH_PENDING_BIT] & instr_miss_f_o;
   assign redirect  = pc_src_reg_i[PC_SRC_REDIRECT_BIT];
   always_ff @(posedge clk_i)
      delay_applied <= reset_i ? ST_NORMAL : next_state;
   // A delay never lasts more than one cycle: DELAYED always falls back to NORMAL.
   always_comb
      next_state = (delay_applied == ST_NORMAL && stall_req) ? ST_DELAYED : ST_NORMAL;
   always_comb
      instr_cache_rep_active_o = (delay_applied == ST_DELAYED) ? ~redirect : ~stall_req;
`ifdef INSTR_CACHE_CTLR_STATS_EN
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         delay_count_o  <= '0;
         squash_count_o <= '0;
      end else begin
         if (delay_applied == ST_NORMAL && next_state == ST_DELAYED)
            delay_count_o <= delay_count_o + 32'd1;
         if (delay_applied == ST_DELAYED && redirect)
            squash_count_o <= squash_count_o + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_instr_cache_ctlr.sv
// tb_instr_cache_ctlr: directed stimulus with a behavioural replacement-hold model checked every cycle.
module tb_instr_cache_ctlr;
   localparam logic [63:0] PATTERN = 64'h0123456789ABCDEF;
   logic        clk, reset;
   logic [5:0]  set_idx;
   logic [63:0] miss_array;
   logic [1:0]  pc_src, branch_op;
   logic [63:0] active_array;
   logic        miss_f, rep_active;
`ifdef INSTR_CACHE_CTLR_STATS_EN
   logic [31:0] delay_count, squash_count;
`endif
   int compared = 0, mismatched = 0;
   bit m_valid = 0, m_delayed = 0, held;
   int unsigned m_dcnt = 0, m_scnt = 0;

   instr_cache_ctlr dut (
      .clk_i                    (clk),
      .reset_i                  (reset),
      .set_i                    (set_idx),
      .miss_array_i             (miss_array),
      .pc_src_reg_i             (pc_src),
      .branch_op_e_i            (branch_op),
      .active_array_o           (active_array),
      .instr_miss_f_o           (miss_f),
      .instr_cache_rep_active_o (rep_active)
`ifdef INSTR_CACHE_CTLR_STATS_EN
      ,
      .delay_count_o            (delay_count),
      .squash_count_o           (squash_count)
`endif
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a miss seen under a pending branch holds replacement and opens a one-cycle window.
   always @(posedge clk) begin
      if (reset) begin
         m_valid <= 1;
         m_delayed <= 0;
         m_dcnt <= 0;
         m_scnt <= 0;
      end else begin
         held = !m_delayed && branch_op[0] && miss_array[set_idx];
         if (held) m_dcnt <= m_dcnt + 1;
         if (m_delayed && pc_src[1]) m_scnt <= m_scnt + 1;
         m_delayed <= held;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("active_array", active_array, 64'd1 << set_idx);
         chk("miss_f", 64'(miss_f), 64'(miss_array[set_idx]));
         chk("rep_active", 64'(rep_active),
             64'(m_delayed ? !pc_src[1] : !(branch_op[0] && miss_array[set_idx])));
         chk("delay_applied", 64'(dut.delay_applied), 64'(m_delayed));
`ifdef INSTR_CACHE_CTLR_STATS_EN
         chk("delay_count", 64'(delay_count), 64'(m_dcnt));
         chk("squash_count", 64'(squash_count), 64'(m_scnt));
`endif
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1; set_idx = 0; miss_array = PATTERN; pc_src = 0; branch_op = 0;
      cyc();
      for (int k = 0; k < 64; k++) begin
         set_idx = 6'(k);
         #1;
         chk("sweep_onehot", 64'($countones(active_array)), 64'd1);
         chk("sweep_active_bit", 64'(active_array[k]), 64'd1);
         chk("sweep_miss", 64'(miss_f), 64'(PATTERN[k]));
      end
      cyc();
      reset = 0; miss_array = 0; set_idx = 6'd9;
      cyc(); cyc();
      chk("idle_hit_state", 64'(dut.delay_applied), 64'd0);
      chk("idle_hit_rep", 64'(rep_active), 64'd1);
      miss_array = '1;
      cyc(); cyc();
      chk("nobranch_miss_state", 64'(dut.delay_applied), 64'd0);
      chk("nobranch_miss_rep", 64'(rep_active), 64'd1);
      branch_op = 2'b01; miss_array = 0;
      cyc();
      chk("branch_hit_state", 64'(dut.delay_applied), 64'd0);
      chk("branch_hit_rep", 64'(rep_active), 64'd1);
      branch_op = 2'b10; miss_array = '1;
      #1 chk("ignored_bit1_rep", 64'(rep_active), 64'd1);
      cyc();
      chk("ignored_bit1_state", 64'(dut.delay_applied), 64'd0);
      branch_op = 2'b01; pc_src = 2'b01;
      #1 chk("correct_pre_rep", 64'(rep_active), 64'd0);
      cyc();
      branch_op = 0;
      #1;
      chk("correct_delayed", 64'(dut.delay_applied), 64'd1);
      chk("correct_rep", 64'(rep_active), 64'd1);
      cyc();
      chk("correct_back", 64'(dut.delay_applied), 64'd0);
      branch_op = 2'b01; pc_src = 2'b10;
      cyc();
      chk("mispredict_delayed", 64'(dut.delay_applied), 64'd1);
      chk("mispredict_rep", 64'(rep_active), 64'd0);
      branch_op = 0;
      cyc();
      chk("mispredict_back", 64'(dut.delay_applied), 64'd0);
      pc_src = 0;
      #1 chk("mispredict_after_rep", 64'(rep_active), 64'd1);
`ifdef INSTR_CACHE_CTLR_STATS_EN
      chk("lit_delay_count", 64'(delay_count), 64'd2);
      chk("lit_squash_count", 64'(squash_count), 64'd1);
`endif
      branch_op = 2'b01; miss_array = PATTERN; set_idx = 6'd4;
      cyc();
      chk("pattern_set4_hit", 64'(dut.delay_applied), 64'd0);
      set_idx = 6'd63;
      cyc();
      chk("pattern_set63_hit", 64'(dut.delay_applied), 64'd0);
      set_idx = 6'd1;
      cyc();
      chk("pattern_set1_miss", 64'(dut.delay_applied), 64'd1);
      cyc();
      chk("back_to_back_release", 64'(dut.delay_applied), 64'd0);
      cyc();
      chk("back_to_back_again", 64'(dut.delay_applied), 64'd1);
      reset = 1;
      cyc();
      chk("reset_in_delayed", 64'(dut.delay_applied), 64'd0);
`ifdef INSTR_CACHE_CTLR_STATS_EN
      chk("reset_delay_count", 64'(delay_count), 64'd0);
      chk("reset_squash_count", 64'(squash_count), 64'd0);
`endif
      reset = 0; branch_op = 0;
      cyc(); cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/instr_cache_ctlr.md
Name: instr_cache_ctlr

Overview:
- Control block for the set-associative instruction cache in the fetch stage of the pipelined RISC-V core.
- Decodes the fetch set index into a one-hot set-enable vector.
- Selects that set's miss flag as the fetch-stage miss.
- Gates cache line replacement while a branch in Execute is unresolved, so a wrong-path fetch cannot evict a line.

Parameters:
- NUM_SETS, 64, number of cache sets (a power of 2).
- SET_BITS, 6, index width, equal to log2(NUM_SETS).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- set_i  in  SET_BITS  set index of the current fetch address.
- miss_array_i  in  NUM_SETS  per-set miss flags; bit k=1 means set k misses.
- pc_src_reg_i  in  2  registered PC-source/redirect; bit 1=1 means the branch resolved as mispredicted/redirected; bit 0 is ignored.
- branch_op_e_i  in  2  branch op in Execute; bit 0=1 means a branch/jump is pending; bit 1 is ignored.
- active_array_o  out  NUM_SETS  one-hot set enable.
- instr_miss_f_o  out  1  fetch miss.
- instr_cache_rep_active_o  out  1  replacement enable; 1 lets a missing set refill.

Behaviour:
- Clock and reset: one clock (clk_i); reset_i is synchronous and active-high. Both are fixed.
- active_array_o: purely combinational; bit set_i is 1 and all other bits are 0. It ignores reset and state.
- instr_miss_f_o: equals miss_array_i[set_i]; combinational, zero latency, independent of reset.
- FSM state: one register holding the state, named delay_applied (the name is fixed for hierarchical probing).
  - NORMAL (delay_applied=0).
  - DELAYED (delay_applied=1).
- Reset: at a rising edge with reset_i=1, state becomes NORMAL. Reset has priority over every transition.
- NORMAL -> DELAYED at a rising edge when branch_op_e_i[0]=1 and instr_miss_f_o=1. Otherwise the FSM stays in NORMAL.
- DELAYED -> NORMAL unconditionally at the next rising edge, so a delay never lasts more than one cycle.
- instr_cache_rep_active_o is combinational:
  - In NORMAL: NOT(branch_op_e_i[0] AND instr_miss_f_o). A miss under a pending branch holds off replacement for that cycle.
  - In DELAYED: NOT pc_src_reg_i[1]. The held refill proceeds if the branch was predicted correctly and is suppressed if it was mispredicted.
- A hit, or a miss with no pending branch, gives rep_active=1 with no state change.
- Reset does not force rep_active_o; it follows the equations above with state=NORMAL.
- Reset asserted while in DELAYED returns the FSM to NORMAL at that edge.
- Out-of-range set_i is impossible (NUM_SETS=2^SET_BITS).

Optional Feature:
- Macro: INSTR_CACHE_CTLR_STATS_EN.
- When defined, the block adds two outputs, each a 32-bit counter:
  - delay_count_o counts NORMAL->DELAYED transitions.
  - squash_count_o counts cycles in DELAYED with pc_src_reg_i[1]=1.
- Both counters reset to 0 synchronously and wrap at 2^32.
- When undefined, neither the ports nor the counters exist and behaviour is otherwise identical.

Decomposition:
- Shared package instr_cache_pkg holds:
  - NUM_SETS and SET_BITS defaults.
  - The state enum {ST_NORMAL=1'b0, ST_DELAYED=1'b1}.
  - Bit-position constants BRANCH_PENDING_BIT=0 and PC_SRC_REDIRECT_BIT=1.
- One natural sub-module, instr_cache_set_sel, holds the one-hot decoder and the miss mux. The FSM stays in the top module.

Test Plan:
- reset_i=1, miss_array_i=64'h0123456789ABCDEF, sweep set_i 0..63 -> active_array_o[set_i]=1 and one-hot; instr_miss_f_o=miss_array_i[set_i].
- reset_i=0, branch_op_e_i=0, with miss_array_i=0 then all-ones -> delay_applied stays 0 and rep_active=1 across edges.
- branch_op_e_i[0]=1, miss_array_i=0 -> after an edge, delay_applied=0 and rep_active=1.
- Correct branch: branch_op_e_i[0]=1, miss_array_i all-ones, pc_src_reg_i=0 -> rep_active=0 before the edge; after the edge delay_applied=1 and rep_active=1; one edge later delay_applied=0.
- Mispredict: same miss under branch, pc_src_reg_i[1]=1 at the edge -> delay_applied=1 and rep_active=0; next edge delay_applied=0; with branch_op_e_i=0 and pc_src_reg_i=0, rep_active=1.
- Reset asserted while delay_applied=1 -> NORMAL after the edge; with STATS_EN defined, both counters read 0.
